// File: rtl/uc_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uc_multiciclo_pkg
//  Description : Shared opcode field constants, FSM state encoding and
//                helpers for the multi-cycle control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uc_multiciclo_pkg;

    localparam int OPCODE_W = 6;
    localparam int OP_ALU_W = 3;

    // Major opcode field is opcode[5:2]; bit 3 of that field marks ALU ops.
    localparam int         ALU_PREFIX_BIT = 3;
    localparam logic [3:0] OP_LI          = 4'b0000;
    localparam logic [3:0] OP_J           = 4'b0001;
    localparam logic [3:0] OP_JZ          = 4'b0010;
    localparam logic [3:0] OP_JNZ         = 4'b0011;
    localparam logic [3:0] OP_NOP         = 4'b0100;
    localparam logic [3:0] OP_HALT        = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // A program-memory wait of zero still needs one FETCH cycle.
    function automatic logic [2:0] fetch_cycles(input int unsigned fw);
        return (fw == 0) ? 3'd1 : 3'(fw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : uc_decode
//  Description : Purely combinational opcode/zero-flag decoder producing the
//                datapath controls for a single EXEC cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_decode
    import uc_multiciclo_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [OP_ALU_W-1:0] op_alu,
    output logic                pc_en,
    output logic                is_halt,
    output logic                is_illegal
);

    logic [3:0] w_major;
    logic       w_unused_low_bits;

    assign w_major           = opcode[5:2];
    // Low opcode bits carry operand fields that the control unit never uses.
    assign w_unused_low_bits = ^opcode[1:0];

    // Decode major opcode field into datapath controls
    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op_alu     = '0;
        pc_en      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (w_major[ALU_PREFIX_BIT]) begin
            we3    = 1'b1;
            wez    = 1'b1;
            op_alu = opcode[4:2];
            pc_en  = 1'b1;
        end else begin
            case (w_major)
                OP_LI: begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                    pc_en = 1'b1;
                end
                OP_J: begin
                    s_inc = 1'b0;
                    pc_en = 1'b1;
                end
                OP_JZ: begin
                    s_inc = ~z;
                    pc_en = 1'b1;
                end
                OP_JNZ: begin
                    s_inc = z;
                    pc_en = 1'b1;
                end
                OP_NOP: begin
                    pc_en = 1'b1;
                end
                OP_HALT: begin
                    // PC holds so a restart re-fetches past nothing.
                    is_halt = 1'b1;
                end
                default: begin
                    // Unknown encodings execute as NOP and raise the flag.
                    pc_en      = 1'b1;
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : uc_multiciclo
//  Description : Multi-cycle control unit. Sequences FETCH/EXEC, gates the
//                decoded controls to EXEC, and adds run/halt, single-step
//                handshake, sticky illegal flag and retired-instruction count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FETCH_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step_req,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [OP_ALU_W-1:0] op_alu,
    output logic                pc_en,
    output logic                busy,
    output logic                halted,
    output logic                step_ack,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_cnt
);

    localparam logic [2:0] C_FETCH_LAST = fetch_cycles(FETCH_WAIT) - 3'd1;

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_wait_cnt;
    logic                 r_step_req_q;
    logic                 r_illegal;
    logic [CNT_W-1:0]     r_instr_cnt;

    logic                 w_exec;
    logic                 w_step_rise;
    logic                 w_step_ack;
    logic                 w_dec_s_inc;
    logic                 w_dec_s_inm;
    logic                 w_dec_we3;
    logic                 w_dec_wez;
    logic [OP_ALU_W-1:0]  w_dec_op_alu;
    logic                 w_dec_pc_en;
    logic                 w_dec_halt;
    logic                 w_dec_illegal;

    uc_decode u_decode (
        .opcode     (opcode),
        .z          (z),
        .s_inc      (w_dec_s_inc),
        .s_inm      (w_dec_s_inm),
        .we3        (w_dec_we3),
        .wez        (w_dec_wez),
        .op_alu     (w_dec_op_alu),
        .pc_en      (w_dec_pc_en),
        .is_halt    (w_dec_halt),
        .is_illegal (w_dec_illegal)
    );

    assign w_exec      = (r_state == ST_EXEC);
    // A held-high request must not re-trigger, so only a fresh rise counts.
    assign w_step_rise = step_req & ~r_step_req_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FETCH dwell counter, cleared whenever FETCH is left or not yet entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 3'd0;
        end else if ((r_state == ST_FETCH) && (r_wait_cnt != C_FETCH_LAST)) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end else begin
            r_wait_cnt <= 3'd0;
        end
    end

    // Previous step request level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_req_q <= 1'b0;
        end else begin
            r_step_req_q <= step_req;
        end
    end

    // Sticky illegal flag and retired-instruction counter, updated at EXEC end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal   <= 1'b0;
            r_instr_cnt <= '0;
        end else if (w_exec) begin
            if (w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
            if (!w_dec_halt) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic and step handshake
    always_comb begin
        w_next_state = r_state;
        w_step_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (r_wait_cnt == C_FETCH_LAST) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_dec_halt)     w_next_state = ST_HALT;
                else if (step_mode) w_next_state = ST_WAIT_STEP;
                else                w_next_state = ST_FETCH;
            end
            ST_WAIT_STEP: begin
                if (!step_mode) begin
                    w_next_state = ST_FETCH;
                end else if (w_step_rise) begin
                    w_step_ack   = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath controls are live only in EXEC; elsewhere they rest at idle values
    always_comb begin
        s_inc  = w_exec ? w_dec_s_inc  : 1'b1;
        s_inm  = w_exec & w_dec_s_inm;
        we3    = w_exec & w_dec_we3;
        wez    = w_exec & w_dec_wez;
        op_alu = w_exec ? w_dec_op_alu : '0;
        pc_en  = w_exec & w_dec_pc_en;
    end

    assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                       (r_state == ST_WAIT_STEP);
    assign halted    = (r_state == ST_HALT);
    assign step_ack  = w_step_ack;
    assign illegal   = r_illegal;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uc_multiciclo
//  Description : Self-checking bench for uc_multiciclo. Two instances run in
//                lockstep: a 16-bit counter with FETCH_WAIT=1 and a 4-bit
//                counter with FETCH_WAIT=0 (which must behave as 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       step_mode;
    logic       step_req;
    logic [5:0] opcode;
    logic       z;

    logic        s_inc_a, s_inm_a, we3_a, wez_a, pc_en_a;
    logic [2:0]  op_alu_a;
    logic        busy_a, halted_a, step_ack_a, illegal_a;
    logic [15:0] cnt_a;

    logic        s_inc_b, s_inm_b, we3_b, wez_b, pc_en_b;
    logic [2:0]  op_alu_b;
    logic        busy_b, halted_b, step_ack_b, illegal_b;
    logic [3:0]  cnt_b;

    logic [7:0]  ctrl_a, ctrl_b;
    assign ctrl_a = {s_inc_a, s_inm_a, we3_a, wez_a, op_alu_a, pc_en_a};
    assign ctrl_b = {s_inc_b, s_inm_b, we3_b, wez_b, op_alu_b, pc_en_b};

    int          checks = 0;
    int          errors = 0;
    int unsigned m_cnt  = 0;
    bit          m_ill  = 1'b0;

    always #5 clk = ~clk;

    uc_multiciclo #(.CNT_W(16), .FETCH_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step_req(step_req), .opcode(opcode), .z(z),
        .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a), .wez(wez_a),
        .op_alu(op_alu_a), .pc_en(pc_en_a), .busy(busy_a), .halted(halted_a),
        .step_ack(step_ack_a), .illegal(illegal_a), .instr_cnt(cnt_a)
    );

    uc_multiciclo #(.CNT_W(4), .FETCH_WAIT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step_req(step_req), .opcode(opcode), .z(z),
        .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b), .wez(wez_b),
        .op_alu(op_alu_b), .pc_en(pc_en_b), .busy(busy_b), .halted(halted_b),
        .step_ack(step_ack_b), .illegal(illegal_b), .instr_cnt(cnt_b)
    );

    // Reference decode: {s_inc, s_inm, we3, wez, op_alu[2:0], pc_en}
    function automatic logic [7:0] exp_ctrl(input logic [5:0] op, input logic zz);
        int         m;
        logic [2:0] alu;
        m   = int'(op) / 4;
        alu = 3'(m % 8);
        if (m >= 8) return {4'b1011, alu, 1'b1};
        case (m)
            0:       return {4'b1110, 3'b000, 1'b1};
            1:       return {4'b0000, 3'b000, 1'b1};
            2:       return {~zz, 3'b000, 3'b000, 1'b1};
            3:       return {zz, 3'b000, 3'b000, 1'b1};
            7:       return 8'b1000_0000;
            default: return 8'b1000_0001;
        endcase
    endfunction

    function automatic bit op_is_halt(input logic [5:0] op);
        return (int'(op) / 4) == 7;
    endfunction

    function automatic bit op_is_illegal(input logic [5:0] op);
        return ((int'(op) / 4) == 5) || ((int'(op) / 4) == 6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("cnt_a", 32'(cnt_a), m_cnt % 65536);
        chk("cnt_b", 32'(cnt_b), m_cnt % 16);
        chk("illegal_a", 32'(illegal_a), 32'(m_ill));
        chk("illegal_b", 32'(illegal_b), 32'(m_ill));
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge after EXEC.
    task automatic exec_instr(input logic [5:0] op, input logic zz, input logic sm);
        logic [7:0] e;
        opcode    = op;
        z         = 1'($urandom);
        start     = 1'($urandom);
        step_mode = sm;
        #1;
        chk("fetch_busy", 32'(busy_a), 1);
        chk("fetch_ctrl_a", 32'(ctrl_a), 32'h80);
        chk("fetch_ctrl_b", 32'(ctrl_b), 32'h80);
        @(negedge clk);
        z     = zz;
        start = 1'($urandom);
        #1;
        e = exp_ctrl(op, zz);
        chk("exec_ctrl_a", 32'(ctrl_a), 32'(e));
        chk("exec_ctrl_b", 32'(ctrl_b), 32'(e));
        if (!op_is_halt(op)) m_cnt++;
        if (op_is_illegal(op)) m_ill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_cnt();
        chk("after_halted", 32'(halted_a), 32'(op_is_halt(op)));
        chk("after_busy", 32'(busy_a), 32'(!op_is_halt(op)));
        chk("after_busy_b", 32'(busy_b), 32'(!op_is_halt(op)));
        if (sm && !op_is_halt(op)) chk("wait_pc_en", 32'(pc_en_a), 0);
    endtask

    // From HALT, restart and land at the negedge in FETCH.
    task automatic resume_from_halt();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("resume_halted", 32'(halted_a), 0);
        chk("resume_busy", 32'(busy_a), 1);
    endtask

    // From WAIT_STEP, issue one fresh step request and land in FETCH.
    task automatic do_step();
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1 chk("wait_no_ack", 32'(step_ack_a), 0);
        end
        @(negedge clk);
        step_req = 1'b1;
        #1;
        chk("step_ack_a", 32'(step_ack_a), 1);
        chk("step_ack_b", 32'(step_ack_b), 1);
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic random_legal(output logic [5:0] op);
        op = 6'($urandom);
        while (op_is_halt(op) || op_is_illegal(op)) op = 6'($urandom);
    endtask

    initial begin
        logic [5:0] op;
        logic       sm;
        int         acks, execs;

        reset = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        opcode = 6'b101000; z = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_ctrl_a", 32'(ctrl_a), 32'h80);
        chk("rst_ctrl_b", 32'(ctrl_b), 32'h80);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_halted", 32'(halted_a), 0);
        chk("rst_ack", 32'(step_ack_a), 0);
        chk_cnt();

        // Leave reset; IDLE holds until start.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("idle_busy", 32'(busy_a), 0);
        start = 1'b1;
        @(negedge clk);

        // ALU op, then conditional/unconditional jumps, LI and NOP.
        exec_instr(6'b101000, 1'b0, 1'b0);
        exec_instr(6'b001000, 1'b1, 1'b0);
        exec_instr(6'b001000, 1'b0, 1'b0);
        exec_instr(6'b001100, 1'b1, 1'b0);
        exec_instr(6'b001100, 1'b0, 1'b0);
        exec_instr(6'b000101, 1'b1, 1'b0);
        exec_instr(6'b000010, 1'b0, 1'b0);
        exec_instr(6'b010011, 1'b1, 1'b0);

        // Step mode: a held request yields exactly one ack and one EXEC.
        exec_instr(6'b110100, 1'b0, 1'b1);
        @(negedge clk); #1 chk("wait_ack0", 32'(step_ack_a), 0);
        @(negedge clk); #1 chk("wait_busy", 32'(busy_a), 1);
        chk("wait_cnt_hold", 32'(cnt_a), m_cnt % 65536);
        @(negedge clk);
        step_req = 1'b1;
        acks = 0; execs = 0;
        #1;
        acks += int'(step_ack_a); execs += int'(pc_en_a);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            acks += int'(step_ack_a); execs += int'(pc_en_a);
        end
        m_cnt++;
        chk("held_req_acks", 32'(acks), 1);
        chk("held_req_execs", 32'(execs), 1);
        chk_cnt();
        @(negedge clk);
        step_req = 1'b0;
        do_step();
        exec_instr(6'b010000, 1'b0, 1'b1);
        // Leaving step mode releases WAIT_STEP without an ack.
        step_mode = 1'b0;
        #1 chk("drop_mode_ack", 32'(step_ack_a), 0);
        @(negedge clk);
        exec_instr(6'b111000, 1'b1, 1'b0);

        // HALT: no retire, halted next cycle, start resumes.
        exec_instr(6'b011100, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk("halt_hold", 32'(halted_a), 1);
        chk("halt_cnt_hold", 32'(cnt_a), m_cnt % 65536);
        resume_from_halt();

        // Illegal opcode is sticky across later legal instructions.
        chk("pre_illegal", 32'(illegal_a), 0);
        exec_instr(6'b010100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            random_legal(op);
            exec_instr(op, 1'($urandom), 1'b0);
        end
        chk("illegal_sticky", 32'(illegal_a), 1);

        // Random instruction stream with occasional stepping and halts.
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom);
            sm = ($urandom_range(0, 3) == 0);
            exec_instr(op, 1'($urandom), sm);
            if (op_is_halt(op)) resume_from_halt();
            else if (sm) do_step();
        end

        // Asynchronous reset in the middle of an LI execute.
        opcode = 6'b000011;
        @(negedge clk);
        #1 chk("li_we3", 32'(we3_a), 1);
        reset = 1'b0;
        #1;
        chk("async_we3_a", 32'(we3_a), 0);
        chk("async_we3_b", 32'(we3_b), 0);
        chk("async_busy", 32'(busy_a), 0);
        m_cnt = 0;
        m_ill = 1'b0;
        chk_cnt();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);

        // 16 retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            random_legal(op);
            exec_instr(op, 1'($urandom), 1'b0);
        end
        chk("wrap_cnt_b", 32'(cnt_b), 0);
        chk("wrap_cnt_a", 32'(cnt_a), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
